uart_rx_byte: RTL and testbench

Serial-to-parallel receive stage that recovers 8-N-1 asynchronous frames from a single serial line and presents each byte as an 8-bit word with a one-cycle strobe. It sits directly upstream of the 8-bit enable-loaded data register. `data` drives the register's `d`, and `valid` drives its `en`, so the register captures exactly one clean byte per good frame. Bit timing comes from a fixed clocks-per-bit count. Framing errors are flagged and never strobed downstream.

---
 rtl/uart_rx_byte.sv | 117 +++++++++++
 tb/tb_uart_rx_byte.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// 8-N-1 serial receiver: recovers one byte per frame from rx and strobes it out.
// Good frames pulse valid with data updated; a low stop bit pulses frame_err instead.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("uart_rx_byte: CLKS_PER_BIT must be at least 4");
  end

  logic          rx_m;
  logic          rx_s;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        // Half a bit in: confirm the start bit is still low to reject glitches.
        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (rx_s) begin
              state <= S_IDLE;
            end else begin
              state   <= S_DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Returning to IDLE mid stop bit lets a back-to-back start bit be caught.
        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              data  <= shreg;
              valid <= 1'b1;
              state <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (rx_s) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: directed scenarios plus random frames, two instances
// (16 and 4 clocks per bit) checked against expected pulse times and bytes.
module tb_uart_rx_byte;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic rx16  = 1'b1;
  logic rx4   = 1'b1;

  logic [7:0] data16, data4;
  logic       valid16, valid4, ferr16, ferr4, busy16, busy4;

  uart_rx_byte #(.CLKS_PER_BIT(16)) dut16 (
    .clk(clk), .reset(reset), .rx(rx16),
    .data(data16), .valid(valid16), .frame_err(ferr16), .busy(busy16)
  );

  uart_rx_byte #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .reset(reset), .rx(rx4),
    .data(data4), .valid(valid4), .frame_err(ferr4), .busy(busy4)
  );

  // clock / cycle counter: cyc holds the index of the latest rising edge
  always #5 clk = ~clk;

  logic [31:0] cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: record every strobe with the edge it followed
  logic [31:0] act_vcyc[2][$];
  logic [7:0]  act_vdat[2][$];
  logic [31:0] act_ecyc[2][$];
  logic [31:0] busy_cycles[2] = '{0, 0};
  int          both_cnt = 0;

  always @(negedge clk) begin
    if (valid16) begin
      act_vcyc[0].push_back(cyc);
      act_vdat[0].push_back(data16);
    end
    if (ferr16) act_ecyc[0].push_back(cyc);
    if (valid4) begin
      act_vcyc[1].push_back(cyc);
      act_vdat[1].push_back(data4);
    end
    if (ferr4) act_ecyc[1].push_back(cyc);
    if (busy16) busy_cycles[0] = busy_cycles[0] + 1;
    if (busy4)  busy_cycles[1] = busy_cycles[1] + 1;
    if ((valid16 && ferr16) || (valid4 && ferr4)) both_cnt++;
  end

  // scoreboard
  logic [31:0] exp_cyc[2][$];
  logic [7:0]  exp_dat[2][$];
  logic [31:0] exp_err[2][$];
  logic [7:0]  dmodel[2] = '{8'h00, 8'h00};
  int          rd_v[2] = '{0, 0};
  int          rd_e[2] = '{0, 0};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int n_of(input int s);
    return (s == 0) ? 16 : 4;
  endfunction

  function automatic logic [31:0] data_of(input int s);
    return (s == 0) ? 32'(data16) : 32'(data4);
  endfunction

  function automatic logic [31:0] busy_of(input int s);
    return (s == 0) ? 32'(busy16) : 32'(busy4);
  endfunction

  function automatic logic [31:0] valid_of(input int s);
    return (s == 0) ? 32'(valid16) : 32'(valid4);
  endfunction

  function automatic logic [31:0] ferr_of(input int s);
    return (s == 0) ? 32'(ferr16) : 32'(ferr4);
  endfunction

  // driver tasks: all are entered and left 1 time unit after a rising edge
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int s, input logic v);
    if (s == 0) rx16 = v;
    else        rx4  = v;
  endtask

  task automatic send_frame(input int s, input logic [7:0] b, input logic stop,
                            output logic [31:0] t_fall);
    int n;
    n = n_of(s);
    t_fall = cyc;
    drive(s, 1'b0);
    idle(n);
    for (int i = 0; i < 8; i++) begin
      drive(s, b[i]);
      idle(n);
    end
    drive(s, stop);
    idle(n);
  endtask

  // Line falls after edge t_fall; two sync stages put T0 at t_fall+3, and the
  // stop bit is sampled H + 9 bit periods after T0.
  task automatic expect_frame(input int s, input logic [7:0] b, input logic good,
                              input logic [31:0] t_fall);
    int n;
    logic [31:0] t_ev;
    n = n_of(s);
    t_ev = t_fall + 32'(3 + n / 2 + 9 * n);
    if (good) begin
      exp_cyc[s].push_back(t_ev);
      exp_dat[s].push_back(b);
      dmodel[s] = b;
    end else begin
      exp_err[s].push_back(t_ev);
    end
  endtask

  task automatic compare_events(input int s);
    logic [31:0] e;
    logic [7:0]  d;
    check_eq("valid_count", 32'(act_vcyc[s].size() - rd_v[s]), 32'(exp_cyc[s].size()));
    while (exp_cyc[s].size() > 0) begin
      e = exp_cyc[s].pop_front();
      d = exp_dat[s].pop_front();
      if (rd_v[s] < act_vcyc[s].size()) begin
        check_eq("valid_cycle", act_vcyc[s][rd_v[s]], e);
        check_eq("valid_data", 32'(act_vdat[s][rd_v[s]]), 32'(d));
      end
      rd_v[s]++;
    end
    rd_v[s] = act_vcyc[s].size();
    check_eq("ferr_count", 32'(act_ecyc[s].size() - rd_e[s]), 32'(exp_err[s].size()));
    while (exp_err[s].size() > 0) begin
      e = exp_err[s].pop_front();
      if (rd_e[s] < act_ecyc[s].size()) check_eq("ferr_cycle", act_ecyc[s][rd_e[s]], e);
      rd_e[s]++;
    end
    rd_e[s] = act_ecyc[s].size();
    check_eq("data_held", data_of(s), 32'(dmodel[s]));
    check_eq("busy_idle", busy_of(s), 0);
  endtask

  initial begin
    logic [31:0] t;
    logic [31:0] b0;
    int          k;
    logic [7:0]  rb;
    logic        bad;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check_eq("rst_data", data_of(s), 0);
      check_eq("rst_valid", valid_of(s), 0);
      check_eq("rst_ferr", ferr_of(s), 0);
      check_eq("rst_busy", busy_of(s), 0);
    end
    reset = 1'b1;
    idle(5);

    // single byte
    send_frame(0, 8'hA5, 1'b1, t);
    expect_frame(0, 8'hA5, 1'b1, t);
    idle(10);
    compare_events(0);

    // back-to-back with no idle gap
    k = act_vcyc[0].size();
    send_frame(0, 8'h00, 1'b1, t);
    expect_frame(0, 8'h00, 1'b1, t);
    send_frame(0, 8'hFF, 1'b1, t);
    expect_frame(0, 8'hFF, 1'b1, t);
    idle(10);
    if (act_vcyc[0].size() >= k + 2)
      check_eq("b2b_gap", act_vcyc[0][k+1] - act_vcyc[0][k], 160);
    else
      check_eq("b2b_pulses", 32'(act_vcyc[0].size() - k), 2);
    compare_events(0);

    // glitch shorter than half a bit
    b0 = busy_cycles[0];
    rx16 = 1'b0;
    idle(4);
    rx16 = 1'b1;
    idle(20);
    check_eq("glitch_busy_cycles", busy_cycles[0] - b0, 8);
    compare_events(0);

    // framing error, held break, recovery
    send_frame(0, 8'h3C, 1'b0, t);
    expect_frame(0, 8'h3C, 1'b0, t);
    idle(50);
    check_eq("break_busy", 32'(busy16), 1);
    rx16 = 1'b1;
    idle(2);
    check_eq("break_busy_sync", 32'(busy16), 1);
    idle(1);
    check_eq("break_release", 32'(busy16), 0);
    idle(3);
    send_frame(0, 8'h5A, 1'b1, t);
    expect_frame(0, 8'h5A, 1'b1, t);
    idle(10);
    compare_events(0);

    // reset pulse during data bit 4; remaining line bits are all high
    fork
      send_frame(0, 8'hF0, 1'b1, t);
      begin
        idle(88);
        reset = 1'b0;
        idle(1);
        check_eq("midrst_data", 32'(data16), 0);
        check_eq("midrst_valid", 32'(valid16), 0);
        check_eq("midrst_ferr", 32'(ferr16), 0);
        check_eq("midrst_busy", 32'(busy16), 0);
        reset = 1'b1;
        dmodel[0] = 8'h00;
        dmodel[1] = 8'h00;
      end
    join
    idle(10);
    compare_events(0);
    compare_events(1);
    send_frame(0, 8'hC3, 1'b1, t);
    expect_frame(0, 8'hC3, 1'b1, t);
    idle(10);
    compare_events(0);

    // minimum bit period
    send_frame(1, 8'h81, 1'b1, t);
    expect_frame(1, 8'h81, 1'b1, t);
    idle(10);
    compare_events(1);

    // random frames, occasional bad stop bits with a held-low tail
    for (int i = 0; i < 16; i++) begin
      rb  = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 4) == 0);
      send_frame(0, rb, !bad, t);
      expect_frame(0, rb, !bad, t);
      if (bad) begin
        idle($urandom_range(0, 30));
        rx16 = 1'b1;
        idle($urandom_range(2, 10));
      end else begin
        idle($urandom_range(0, 12));
      end
    end
    idle(20);
    compare_events(0);

    check_eq("valid_ferr_exclusive", 32'(both_cnt), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
